// File: rtl/contact_ram_pkg.sv
// Shared definitions for the contact-record RAM writer.
//   REC_WORDS : number of RAM words that make up one contact record
//   state_e   : controller states (IDLE, WR, RD, DRAIN, DONE)
//   max_rec() : how many whole records fit in a RAM of the given depth
package contact_ram_pkg;

  localparam int unsigned REC_WORDS = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int unsigned max_rec(input int unsigned depth);
    return depth / REC_WORDS;
  endfunction

endpackage

// File: rtl/contact_ram_writer.sv
// contact_ram_writer
//   Upstream controller for the 7-word contact-record RAM. Accepts records over
//   a valid/ready handshake and writes each as one 7-word RAM write. It tracks
//   occupancy and the full flag. On dump_req it reads every stored word back in
//   address order and then empties the store.
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       record handshake; in_w0..in_w6 are the record words
//   dump_req                start a readout of all stored records
//   out_valid/out_data      read-back stream (out_data wired from ram_dout)
//   out_last                final word of the dump
//   dump_busy/dump_done     dump in progress / one-cycle completion pulse
//   full, rec_count         occupancy
//   ram_cs/ram_we/ram_oe    RAM controls
//   ram_addrin/ram_addrout  RAM write base address / read address
//   ram_din0..ram_din6      RAM write words; ram_dout is read data, one cycle late
// Build option
//   CONTACT_DROP_ON_FULL_EN : when defined, records offered while full are
//   accepted and discarded. Each discard is counted on drop_count.
module contact_ram_writer
  import contact_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = 96
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_w0,
  input  logic [DATA_WIDTH-1:0] in_w1,
  input  logic [DATA_WIDTH-1:0] in_w2,
  input  logic [DATA_WIDTH-1:0] in_w3,
  input  logic [DATA_WIDTH-1:0] in_w4,
  input  logic [DATA_WIDTH-1:0] in_w5,
  input  logic [DATA_WIDTH-1:0] in_w6,
  input  logic                  dump_req,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  dump_busy,
  output logic                  dump_done,
  output logic                  full,
  output logic [7:0]            rec_count,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addrin,
  output logic [ADDR_WIDTH-1:0] ram_addrout,
  output logic [DATA_WIDTH-1:0] ram_din0,
  output logic [DATA_WIDTH-1:0] ram_din1,
  output logic [DATA_WIDTH-1:0] ram_din2,
  output logic [DATA_WIDTH-1:0] ram_din3,
  output logic [DATA_WIDTH-1:0] ram_din4,
  output logic [DATA_WIDTH-1:0] ram_din5,
  output logic [DATA_WIDTH-1:0] ram_din6,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef CONTACT_DROP_ON_FULL_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  localparam logic [7:0]            MAX_REC_C  = 8'(max_rec(RAM_DEPTH));
  localparam logic [ADDR_WIDTH-1:0] REC_STRIDE = ADDR_WIDTH'(REC_WORDS);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [7:0]            rec_count_q;
  logic [DATA_WIDTH-1:0] hold_q [REC_WORDS];
  logic [ADDR_WIDTH-1:0] ram_addrin_q;
  logic [ADDR_WIDTH-1:0] ram_addrout_q;
  logic                  ram_cs_q;
  logic                  ram_we_q;
  logic                  ram_oe_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  dump_busy_q;
  logic                  dump_done_q;
  logic [15:0]           drop_count_q;

  logic                  full_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic [ADDR_WIDTH-1:0] last_rd_s;

  assign full_s    = (rec_count_q == MAX_REC_C);
  assign accept_s  = in_valid && in_ready_s;
  // Address of the final stored word. Only used in RD, where rec_count >= 1.
  assign last_rd_s = (ADDR_WIDTH'(rec_count_q) * REC_STRIDE) - ADDR_WIDTH'(1);

  // Ready is only offered in IDLE, and a pending dump request always wins.
  always_comb begin
    in_ready_s = 1'b0;
    if (state_q == IDLE) begin
`ifdef CONTACT_DROP_ON_FULL_EN
      in_ready_s = !dump_req;
`else
      in_ready_s = !full_s && !dump_req;
`endif
    end else begin
      in_ready_s = 1'b0;
    end
  end

  // Controller FSM: state, pointers, hold registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rec_count_q   <= 8'd0;
      for (int i = 0; i < int'(REC_WORDS); i++) hold_q[i] <= '0;
      ram_addrin_q  <= '0;
      ram_addrout_q <= '0;
      ram_cs_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_oe_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      dump_busy_q   <= 1'b0;
      dump_done_q   <= 1'b0;
      drop_count_q  <= 16'd0;
    end else begin
      // Read data arrives one cycle after its address, so the stream flags lag RD by one.
      out_valid_q <= (state_q == RD);
      out_last_q  <= (state_q == RD) && (rd_ptr_q == last_rd_s);
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      dump_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          dump_busy_q <= 1'b0;
          if (dump_req) begin
            rd_ptr_q    <= '0;
            dump_busy_q <= 1'b1;
            if (rec_count_q != 8'd0) begin
              state_q       <= RD;
              ram_cs_q      <= 1'b1;
              ram_oe_q      <= 1'b1;
              ram_addrout_q <= '0;
            end else begin
              state_q     <= DONE;
              dump_done_q <= 1'b1;
            end
          end else if (accept_s && full_s) begin
            // Only reachable with the drop option; the record is discarded.
            state_q <= IDLE;
            if (drop_count_q != 16'hFFFF) begin
              drop_count_q <= drop_count_q + 16'd1;
            end else begin
              drop_count_q <= drop_count_q;
            end
          end else if (accept_s) begin
            hold_q[0]    <= in_w0;
            hold_q[1]    <= in_w1;
            hold_q[2]    <= in_w2;
            hold_q[3]    <= in_w3;
            hold_q[4]    <= in_w4;
            hold_q[5]    <= in_w5;
            hold_q[6]    <= in_w6;
            ram_addrin_q <= wr_ptr_q;
            ram_cs_q     <= 1'b1;
            ram_we_q     <= 1'b1;
            state_q      <= WR;
          end else begin
            state_q <= IDLE;
          end
        end
        WR: begin
          wr_ptr_q    <= wr_ptr_q + REC_STRIDE;
          rec_count_q <= rec_count_q + 8'd1;
          state_q     <= IDLE;
        end
        RD: begin
          if (rd_ptr_q == last_rd_s) begin
            state_q <= DRAIN;
          end else begin
            rd_ptr_q      <= rd_ptr_q + ADDR_WIDTH'(1);
            ram_addrout_q <= rd_ptr_q + ADDR_WIDTH'(1);
            ram_cs_q      <= 1'b1;
            ram_oe_q      <= 1'b1;
            state_q       <= RD;
          end
        end
        DRAIN: begin
          dump_done_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          wr_ptr_q     <= '0;
          rec_count_q  <= 8'd0;
          drop_count_q <= 16'd0;
          dump_busy_q  <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_q;
  assign out_data    = ram_dout;
  assign out_last    = out_last_q;
  assign dump_busy   = dump_busy_q;
  assign dump_done   = dump_done_q;
  assign full        = full_s;
  assign rec_count   = rec_count_q;
  assign ram_cs      = ram_cs_q;
  assign ram_we      = ram_we_q;
  assign ram_oe      = ram_oe_q;
  assign ram_addrin  = ram_addrin_q;
  assign ram_addrout = ram_addrout_q;
  assign ram_din0    = hold_q[0];
  assign ram_din1    = hold_q[1];
  assign ram_din2    = hold_q[2];
  assign ram_din3    = hold_q[3];
  assign ram_din4    = hold_q[4];
  assign ram_din5    = hold_q[5];
  assign ram_din6    = hold_q[6];
`ifdef CONTACT_DROP_ON_FULL_EN
  assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_contact_ram_writer.sv
// Self-checking bench for contact_ram_writer. The bench contains a behavioural
// RAM and a record-level model. The model holds the queue of stored words, the
// expected writes and the expected dump stream. Build with
// CONTACT_DROP_ON_FULL_EN to exercise the drop option.
`timescale 1ns/1ps
module tb_contact_ram_writer;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 96;
  localparam int MAXR  = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] w [7];
  logic          dump_req;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          dump_busy;
  logic          dump_done;
  logic          full;
  logic [7:0]    rec_count;
  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addrin, ram_addrout;
  logic [DW-1:0] din_a [7];
  logic [DW-1:0] ram_dout;
`ifdef CONTACT_DROP_ON_FULL_EN
  logic [15:0]   drop_count;
`endif

  always #5 clk = ~clk;

  contact_ram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_w0(w[0]), .in_w1(w[1]), .in_w2(w[2]), .in_w3(w[3]),
    .in_w4(w[4]), .in_w5(w[5]), .in_w6(w[6]),
    .dump_req(dump_req), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .dump_busy(dump_busy), .dump_done(dump_done),
    .full(full), .rec_count(rec_count),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addrin(ram_addrin), .ram_addrout(ram_addrout),
    .ram_din0(din_a[0]), .ram_din1(din_a[1]), .ram_din2(din_a[2]),
    .ram_din3(din_a[3]), .ram_din4(din_a[4]), .ram_din5(din_a[5]),
    .ram_din6(din_a[6]), .ram_dout(ram_dout)
`ifdef CONTACT_DROP_ON_FULL_EN
    , .drop_count(drop_count)
`endif
  );

  // Behavioural RAM: 7-word write at the base address, registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_cs && ram_we && (ram_addrin + 32'd6 < DEPTH))
      for (int i = 0; i < 7; i++) mem[int'(ram_addrin) + i] <= din_a[i];
    if (ram_cs && ram_oe && (ram_addrout < DEPTH))
      ram_dout <= mem[int'(ram_addrout)];
  end

  // Record-level model state
  int            vec = 0;
  int            errs = 0;
  logic [DW-1:0] store_q [$];
  logic [DW-1:0] wexp_q  [$];
  int unsigned   waddr_q [$];
  logic [DW-1:0] dexp_q  [$];
  int            model_count = 0;
  int            model_drops = 0;
  int unsigned   last_waddr = 0;
  bit            saw91 = 1'b0;
  int            words_out = 0;
  int            done_cycle = -1;
  int            last_cycle = -1;
  int            cyc = 0;
  logic [DW-1:0] first_out, last_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, check writes and dump words against the model.
  always @(negedge clk) begin
    cyc++;
    if (ram_cs && ram_we) begin
      chk("write_expected", 64'(waddr_q.size() != 0), 64'd1);
      if (waddr_q.size() != 0) begin
        chk("wr_addr", ram_addrin, waddr_q.pop_front());
        for (int i = 0; i < 7; i++) chk("wr_word", din_a[i], wexp_q.pop_front());
        chk("wr_oe", ram_oe, 1'b0);
      end
      last_waddr = ram_addrin;
      if (ram_addrin == 32'd91) saw91 = 1'b1;
    end
    if (out_valid) begin
      chk("out_expected", 64'(dexp_q.size() != 0), 64'd1);
      if (dexp_q.size() != 0) begin
        chk("out_data", out_data, dexp_q.pop_front());
        chk("out_last", out_last, 64'(dexp_q.size() == 0));
      end
      if (words_out == 0) first_out = out_data;
      last_out = out_data;
      words_out++;
      if (out_last) last_cycle = cyc;
    end else begin
      chk("out_last_idle", out_last, 1'b0);
    end
    if (dump_done) begin
      done_cycle = cyc;
      chk("done_drained", dexp_q.size(), 0);
    end
  end

  // Offer one record; the model decides whether it must be accepted.
  task automatic send_rec(input logic [DW-1:0] base);
    bit exp_r;
`ifdef CONTACT_DROP_ON_FULL_EN
    exp_r = 1'b1;
`else
    exp_r = (model_count < MAXR);
`endif
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) w[i] = base + DW'(i);
    #1;
    chk("in_ready", in_ready, exp_r);
    @(posedge clk);
    if (exp_r) begin
      if (model_count < MAXR) begin
        waddr_q.push_back(model_count * 7);
        for (int i = 0; i < 7; i++) begin
          wexp_q.push_back(base + DW'(i));
          store_q.push_back(base + DW'(i));
        end
        model_count++;
      end else begin
        model_drops++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Start a dump (optionally with a competing record); abort with reset after abort_after words.
  task automatic do_dump(input bit with_valid, input int abort_after);
    int n;
    int y_cyc;
    int t;
    @(negedge clk);
    dump_req = 1'b1;
    if (with_valid) begin
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) w[i] = 32'hBAD0 + DW'(i);
    end
    #1;
    chk("in_ready_dump", in_ready, 1'b0);
    words_out = 0; done_cycle = -1; last_cycle = -1;
    @(posedge clk);
    n = model_count;
    chk("pending_writes", waddr_q.size(), 0);
    foreach (store_q[i]) dexp_q.push_back(store_q[i]);
    store_q.delete();
    model_count = 0;
    @(negedge clk);
    dump_req = 1'b0;
    in_valid = 1'b0;
    #1;
    y_cyc = cyc;
    chk("dump_busy", dump_busy, 1'b1);
    if (n != 0) begin
      chk("rd_addr0", ram_addrout, 0);
      chk("rd_oe", ram_oe, 1'b1);
    end
    if (abort_after > 0) begin
      t = 0;
      while (words_out < abort_after && t < 100) begin @(negedge clk); #1; t++; end
      chk("abort_words_seen", 64'(words_out >= abort_after), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      dexp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_rec_count", rec_count, 8'd0);
      chk("rst_dump_busy", dump_busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_ram_cs", ram_cs, 1'b0);
      return;
    end
    t = 0;
    while (done_cycle < 0 && t < 300) begin @(negedge clk); #1; t++; end
    chk("dump_done_seen", 64'(done_cycle >= 0), 64'd1);
    chk("words_out", words_out, n * 7);
    if (n != 0) chk("done_after_last", done_cycle - last_cycle, 1);
    else        chk("empty_done_lat", done_cycle, y_cyc);
    @(negedge clk);
    #1;
    chk("post_rec_count", rec_count, 8'd0);
    chk("post_full", full, 1'b0);
    chk("post_busy", dump_busy, 1'b0);
    chk("done_pulse", dump_done, 1'b0);
`ifdef CONTACT_DROP_ON_FULL_EN
    chk("post_drop_count", drop_count, 16'd0);
    model_drops = 0;
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; dump_req = 1'b0;
    for (int i = 0; i < 7; i++) w[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_ctrl", {ram_cs, ram_we, ram_oe}, 3'b000);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_rec_count", rec_count, 8'd0);
    chk("reset_full", full, 1'b0);
    chk("reset_flags", {dump_busy, dump_done, out_last}, 3'b000);
    chk("reset_addrin", ram_addrin, 0);
    chk("reset_din0", din_a[0], 0);

    // One record 0x10..0x16
    send_rec(32'h10);
    #1;
    chk("t1_we", ram_we, 1'b1);
    chk("t1_addrin", ram_addrin, 32'd0);
    chk("t1_din0", din_a[0], 32'h10);
    chk("t1_din6", din_a[6], 32'h16);
    @(negedge clk);
    #1;
    chk("t1_we_off", ram_we, 1'b0);
    chk("t1_rec_count", rec_count, 8'd1);
    do_dump(1'b0, 0);

    // 13 back-to-back records fill the store
    for (int k = 0; k < MAXR; k++) send_rec(32'h1000 + DW'(k) * 32'h10);
    @(negedge clk);
    #1;
    chk("t2_last_addr", last_waddr, 32'd84);
    chk("t2_full", full, 1'b1);
    chk("t2_rec_count", rec_count, 8'd13);
`ifdef CONTACT_DROP_ON_FULL_EN
    send_rec(32'h7000);
    send_rec(32'h7100);
    @(negedge clk);
    #1;
    chk("t6_drop_count", drop_count, 16'd2);
    chk("t6_model_drops", drop_count, 16'(model_drops));
    chk("t6_no_addr91", saw91, 1'b0);
    chk("t6_rec_count", rec_count, 8'd13);
`else
    chk("t2_in_ready", in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) w[i] = 32'h7000 + DW'(i);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_held_off", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t2_still_13", rec_count, 8'd13);
`endif
    do_dump(1'b0, 0);

    // Two records then dump: 14 words in record order
    send_rec(32'h200);
    send_rec(32'h300);
    do_dump(1'b0, 0);
    chk("t3_words", words_out, 14);
    chk("t3_first_word", first_out, 32'h200);
    chk("t3_last_word", last_out, 32'h306);

    // Empty dump
    do_dump(1'b0, 0);
    chk("t4_no_words", words_out, 0);

    // Dump beats a simultaneous record; reset mid-dump
    send_rec(32'h400);
    send_rec(32'h500);
    do_dump(1'b1, 5);
    store_q.delete(); waddr_q.delete(); wexp_q.delete();
    model_count = 0;
    send_rec(32'h600);
    @(negedge clk);
    #1;
    chk("t5_restart_addr", last_waddr, 32'd0);
    chk("t5_rec_count", rec_count, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
